// File: rtl/gatesv_seq_if.sv
// Handshake bundle for gatesv_seq: word input channel and the three-vector result channel.
interface gatesv_seq_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-2:0] out_both;
  logic [W-1:1] out_any;
  logic [W-1:0] out_different;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_both, out_any, out_different
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_both, out_any, out_different
  );
endinterface

// File: rtl/gatesv_seq.sv
// Neighbour-gate evaluator: captures a word, then fills the AND/OR/XOR neighbour
// vectors one 4-bit slice per clock, and holds the result until the sink takes it.
module gatesv_seq #(
  parameter int SLICES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  gatesv_seq_if.slave               bus,
  output logic                      busy,
  output logic [$clog2(SLICES)-1:0] slice
);
  localparam int W  = 4 * SLICES;
  localparam int SW = $clog2(SLICES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  d;
  logic [SW-1:0] cnt;
  logic [W-2:0]  both_r;
  logic [W-1:1]  any_r;
  logic [W-1:0]  diff_r;

  logic [W-2:0]  both_calc;
  logic [W-1:1]  any_calc;
  logic [W-1:0]  diff_calc;
  logic [W-1:0]  mask;
  logic          in_fire;
  logic          out_fire;

  // Full-width neighbour functions; the slice mask picks which bits land each cycle.
  assign both_calc = d[W-2:0] & d[W-1:1];
  assign any_calc  = d[W-1:1] | d[W-2:0];
  assign diff_calc = d ^ {d[0], d[W-1:1]};
  assign mask      = {{(W-4){1'b0}}, 4'hF} << {cnt, 2'b00};

  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign busy          = (state == RUN);
  assign slice         = (state == RUN) ? cnt : '0;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;

  assign bus.out_both      = both_r;
  assign bus.out_any       = any_r;
  assign bus.out_different = diff_r;

  // An accept in DONE implies the result was taken that same edge, so a new word
  // simply restarts RUN without passing through IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      d      <= '0;
      cnt    <= '0;
      both_r <= '0;
      any_r  <= '0;
      diff_r <= '0;
    end else if (in_fire) begin
      state  <= RUN;
      d      <= bus.in_data;
      cnt    <= '0;
      both_r <= '0;
      any_r  <= '0;
      diff_r <= '0;
    end else begin
      case (state)
        RUN: begin
          both_r <= (both_r & ~mask[W-2:0]) | (both_calc & mask[W-2:0]);
          any_r  <= (any_r & ~mask[W-1:1]) | (any_calc & mask[W-1:1]);
          diff_r <= (diff_r & ~mask) | (diff_calc & mask);
          if (cnt == SW'(SLICES - 1)) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gatesv_seq.sv
// Scoreboard bench for gatesv_seq: directed vectors with hand-computed results,
// then a long run of random words against a per-bit reference model.
module tb_gatesv_seq;
  localparam int SLICES = 4;
  localparam int W      = 4 * SLICES;
  localparam int SW     = $clog2(SLICES);

  typedef struct {
    logic [W-2:0] both;
    logic [W-1:1] any;
    logic [W-1:0] diff;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          busy;
  logic [SW-1:0] slice;
  logic          fixed_ready;
  logic          rand_sink;
  logic          rand_bit;

  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  exp_t sb[$];
  exp_t mon_e;

  gatesv_seq_if #(.W(W)) bus ();

  gatesv_seq #(.SLICES(SLICES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .slice (slice)
  );

  always #5 clk = ~clk;

  assign bus.out_ready = rand_sink ? rand_bit : fixed_ready;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d);
    exp_t e;
    e.both = '0;
    e.any  = '0;
    e.diff = '0;
    for (int i = 0; i < W; i++) begin
      if (i < W - 1) e.both[i] = d[i] & d[i+1];
      if (i > 0)     e.any[i]  = d[i] | d[i-1];
      e.diff[i] = d[i] ^ d[(i + 1) % W];
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-2:0] b, input logic [W-1:1] a, input logic [W-1:0] x);
    exp_t e;
    e.both = b;
    e.any  = a;
    e.diff = x;
    return e;
  endfunction

  // Monitor: every accepted result is popped and compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_output("unexpected_result", W'(bus.out_valid), W'(0));
      end else begin
        mon_e = sb.pop_front();
        popped++;
        check_output("out_both", W'(bus.out_both), W'(mon_e.both));
        check_output("out_any", W'(bus.out_any), W'(mon_e.any));
        check_output("out_different", bus.out_different, mon_e.diff);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic apply_stimulus(input logic [W-1:0] word, input exp_t e, input bit push);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("accept_timeout", W'(bus.in_ready), W'(1));
    if (push && bus.in_ready) begin
      sb.push_back(e);
      pushed++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || bus.out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("idle_timeout", W'(busy || bus.out_valid), W'(0));
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_out_valid"}, W'(bus.out_valid), W'(0));
    check_output({tag, "_busy"}, W'(busy), W'(0));
    check_output({tag, "_slice"}, W'(slice), W'(0));
    check_output({tag, "_both"}, W'(bus.out_both), W'(0));
    check_output({tag, "_any"}, W'(bus.out_any), W'(0));
    check_output({tag, "_diff"}, bus.out_different, W'(0));
    check_output({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
  endtask

  initial begin
    int n;
    logic [W-1:0] word;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    fixed_ready  = 1'b0;
    rand_sink    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");

    // Latency: result appears SLICES edges after the accepting edge.
    fixed_ready = 1'b1;
    apply_stimulus(16'h0003, mk(15'h0001, 15'h0003, 16'h8002), 1'b1);
    for (int k = 0; k < SLICES; k++) begin
      check_output("run_slice", W'(slice), W'(k));
      check_output("run_busy", W'(busy), W'(1));
      check_output("run_no_valid", W'(bus.out_valid), W'(0));
      @(posedge clk);
      #1;
    end
    check_output("latency_valid", W'(bus.out_valid), W'(1));
    check_output("done_busy", W'(busy), W'(0));
    wait_idle();

    // Back-to-back words with an always-ready sink.
    apply_stimulus(16'hFFFF, mk(15'h7FFF, 15'h7FFF, 16'h0000), 1'b1);
    apply_stimulus(16'hAAAA, mk(15'h0000, 15'h7FFF, 16'hFFFF), 1'b1);
    wait_idle();

    // Stalled sink: result must hold; in_valid with junk data must be ignored.
    fixed_ready = 1'b0;
    apply_stimulus(16'h8000, mk(15'h0000, 15'h4000, 16'hC000), 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h5555;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      check_output("hold_valid", W'(bus.out_valid), W'(1));
      check_output("hold_in_ready", W'(bus.in_ready), W'(0));
      check_output("hold_both", W'(bus.out_both), W'(0));
      check_output("hold_any", W'(bus.out_any), W'(15'h4000));
      check_output("hold_diff", bus.out_different, 16'hC000);
      @(posedge clk);
      #1;
    end

    // Take the result and accept a new word on the same edge.
    fixed_ready = 1'b1;
    apply_stimulus(16'h0001, mk(15'h0000, 15'h0001, 16'h8001), 1'b1);
    check_output("rerun_busy", W'(busy), W'(1));
    check_output("rerun_slice", W'(slice), W'(0));
    check_output("rerun_valid", W'(bus.out_valid), W'(0));
    wait_idle();

    // Reset in the middle of a word aborts it.
    apply_stimulus(16'h1234, mk('0, '0, '0), 1'b0);
    n = 0;
    while (slice != SW'(2) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("abort_slice", W'(slice), W'(2));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("abort");
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check_output("abort_no_valid", W'(bus.out_valid), W'(0));
    end

    // Random words with random source gaps and random sink backpressure.
    rand_sink = 1'b1;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      word = W'($urandom);
      apply_stimulus(word, model(word), 1'b1);
    end
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("drain_empty", W'(sb.size()), W'(0));
    check_output("drain_count", W'(popped), W'(pushed));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gatesv_seq.md
GATESV_SEQ -- requirements
Module: gatesv_seq

Interface
REQ-001 Parameter: SLICES, default 4, number of 4-bit slices per word; W = 4*SLICES; SLICES SHALL be >= 2.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  source presents a word on in_data.
REQ-005 in_data  input  W  word to process.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_valid  output  1  result outputs hold a complete, stable result.
REQ-008 out_ready  input  1  sink accepts the result this cycle.
REQ-009 out_both  output  W-1  [W-2:0]; bit i = d[i] & d[i+1].
REQ-010 out_any  output  W-1  [W-1:1]; bit i = d[i] | d[i-1].
REQ-011 out_different  output  W  [W-1:0]; bit i = d[i] ^ d[(i+1) mod W], so bit W-1 wraps to d[0].
REQ-012 busy  output  1  high in RUN.
REQ-013 slice  output  clog2(SLICES)  index of the slice evaluated on the next edge; 0 outside RUN.

Function
REQ-014 States SHALL be IDLE, RUN and DONE, encoded in one state register.
REQ-015 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-016 in_ready SHALL be combinational: 1 in IDLE; 1 in DONE when out_ready=1; 0 in RUN.
REQ-017 On in_fire, the block SHALL capture in_data into internal register d, clear all result registers, set the slice counter to 0, and enter RUN.
REQ-018 In RUN, each edge SHALL evaluate slice k, covering bits 4k+3..4k, using neighbour bits d[4k-1] and d[4k+4] (or d[0] for the out_different wrap). It SHALL write only that slice's bits of all three outputs, then increment k.
REQ-019 out_both bit W-1 and out_any bit 0 do not exist; slice 0 SHALL skip out_any[0] and slice SLICES-1 SHALL skip out_both[W-1].
REQ-020 After the edge evaluating slice SLICES-1, the state SHALL be DONE and out_valid SHALL be 1.
REQ-021 Latency: in_fire at edge T gives out_valid=1 after edge T+SLICES.
REQ-022 In DONE, the result outputs and out_valid SHALL hold unchanged until out_fire.
REQ-023 Transitions out of DONE:
- out_fire without in_fire: go to IDLE; out_valid=0.
- out_fire with in_fire in the same cycle: go to RUN with the new word; out_valid=0 on the next cycle.
REQ-024 in_valid in RUN SHALL be ignored; in_data changes after capture SHALL NOT affect the results.
REQ-025 Result outputs SHALL be registered; out_valid and busy SHALL be decoded from state only.
REQ-026 out_valid SHALL never be 1 in IDLE or RUN.

Reset
REQ-027 While reset=1 at an edge, the block SHALL go to IDLE and clear d, the result registers and the slice counter to 0.
REQ-028 After reset: out_valid=0, busy=0, slice=0, all result outputs 0, in_ready=1.
REQ-029 Reset asserted in RUN or DONE SHALL abort the word, with no out_valid afterwards.
REQ-030 Reset SHALL take priority over in_fire and out_fire at the same edge.

Verification (SLICES=4)
REQ-031 in_data=16'h0003, out_ready=1 -> out_valid 4 cycles after accept; out_both=15'h0001, out_any bits 2:1 set and all others 0, out_different=16'h8002.
REQ-032 in_data=16'hFFFF -> out_both=15'h7FFF, out_any all ones, out_different=16'h0000. Then in_data=16'hAAAA -> out_both=0, out_any all ones, out_different=16'hFFFF.
REQ-033 in_data=16'h8000, out_ready=0 for 10 cycles -> out_both=0, only out_any[15] set, out_different=16'hC000. Outputs and out_valid stable throughout; in_ready=0 throughout.
REQ-034 In DONE, raise out_ready and in_valid together with in_data=16'h0001 -> re-enter RUN with no IDLE cycle; the next result gives out_different=16'h8001.
REQ-035 Assert reset at slice=2 -> next cycle state IDLE, outputs 0, in_ready=1; out_valid never asserts for the aborted word.
REQ-036 Random words, random in_valid/out_ready, 500 words -> every result matches the bitwise model of REQ-009..011; results are neither lost nor duplicated.
